// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth signed multiplier.
// One Booth digit per cycle through a shared decoder and adder.
module booth_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] P,
  output logic               busy
);

  localparam int N  = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   b_ext;
  logic [2:0]       code;
  logic [PW-1:0]    a_sx;
  logic [PW-1:0]    mult;
  logic [PW-1:0]    pp;

  // Multiple built at full product width so -2A stays exact for A = min.
  always_comb begin
    b_ext = {b_reg, 1'b0};
    code  = 3'(b_ext >> {cnt, 1'b0});
    a_sx  = {{WIDTH{a_reg[WIDTH-1]}}, a_reg};
    mult  = '0;
    unique case (code)
      3'b001, 3'b010: mult = a_sx;
      3'b011:         mult = a_sx << 1;
      3'b100:         mult = -(a_sx << 1);
      3'b101, 3'b110: mult = -a_sx;
      default:        mult = '0;
    endcase
    pp = mult << {cnt, 1'b0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= A;
            b_reg <= B;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc + pp;
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign P         = acc;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Bench for booth_seq_mult: directed corners plus a
// random back-to-back stream against a signed-product model.
module tb_booth_seq_mult;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;
  logic        busy;

  int vectors;
  int miscompares;

  booth_seq_mult #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(a),
    .B(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .P(p),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_prod(
    input logic [7:0] x,
    input logic [7:0] y
  );
    int sx;
    int sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    return 16'(sx * sy);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(
    input string       tag,
    input logic [7:0]  x,
    input logic [7:0]  y,
    input logic [15:0] exp
  );
    int n;
    a = x;
    b = y;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_ref"}, 32'(exp), 32'(ref_prod(x, y)));
    check(tag, 32'(p), 32'(exp));
    tick();
  endtask

  logic [15:0] q[$];
  logic [15:0] e;
  int cyc;
  int prev;
  int accepted;
  int done;
  bit took;

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (2) tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_p", 32'(p), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(in_ready), 32'd1);

    // 7 x 3: out_valid seen at edge 5 for exactly one cycle
    a = 8'd7;
    b = 8'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("acc_busy", 32'(busy), 32'd1);
    check("acc_ready", 32'(in_ready), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("lat_valid", 32'(out_valid), 32'(k == 4));
    end
    check("p_7x3", 32'(p), 32'h0015);
    tick();
    check("one_cycle", 32'(out_valid), 32'd0);
    check("back_idle", 32'(in_ready), 32'd1);

    run_op("mn_x_mn", 8'h80, 8'h80, 16'h4000);
    run_op("mn_x_mx", 8'h80, 8'h7F, 16'hC080);
    run_op("m1_x_m1", 8'hFF, 8'hFF, 16'h0001);
    run_op("z_x_m77", 8'h00, 8'hB3, 16'h0000);

    // backpressure: DONE held while a new request is waiting
    out_ready = 1'b0;
    a = 8'hFB;
    b = 8'h09;
    in_valid = 1'b1;
    tick();
    a = 8'h03;
    b = 8'h03;
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_p", 32'(p), 32'hFFD3);
      check("bp_ready", 32'(in_ready), 32'd0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_idle", 32'(in_ready), 32'd1);
    check("bp_drop", 32'(out_valid), 32'd0);
    check("bp_hold", 32'(p), 32'hFFD3);

    // reset during the second RUN cycle
    a = 8'd3;
    b = 8'd4;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("ab_valid", 32'(out_valid), 32'd0);
    check("ab_p", 32'(p), 32'd0);
    check("ab_ready", 32'(in_ready), 32'd1);
    tick();
    check("ab_quiet", 32'(out_valid), 32'd0);
    run_op("p12_x_m11", 8'd12, 8'hF5, 16'hFF7C);

    // random back-to-back stream
    cyc = 0;
    prev = -1;
    accepted = 0;
    done = 0;
    a = 8'($urandom);
    b = 8'($urandom);
    while (done < 200 && cyc < 20000) begin
      in_valid = (accepted < 200);
      out_ready = 1'($urandom);
      took = 1'b0;
      #1;
      check("excl", 32'(in_ready & out_valid), 32'd0);
      if (in_valid && in_ready) begin
        q.push_back(ref_prod(a, b));
        if (prev >= 0)
          check("ii", 32'(cyc - prev >= 6), 32'd1);
        prev = cyc;
        accepted++;
        took = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("dup", 32'd0, 32'd1);
        end else begin
          e = q.pop_front();
          check("stream_p", 32'(p), 32'(e));
        end
        done++;
      end
      tick();
      cyc++;
      if (took) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    check("stream_done", 32'(done), 32'd200);
    check("stream_acc", 32'(accepted), 32'd200);
    check("stream_left", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/booth_seq_mult.md
# booth_seq_mult

Sequential radix-4 Booth signed multiplier controller. It accepts one operand pair through a valid/ready handshake and retires one Booth digit per cycle. Each cycle it decodes a 3-bit Booth code, forms the partial product (0, ±A, ±2A) and accumulates it into a 2·WIDTH-bit product register. It time-shares a single partial-product decoder and adder across all digits, for area-constrained datapaths where a full Booth array is too large.

## Interface
- WIDTH, 8, operand width in bits; even, ≥ 4; number of Booth digits N = WIDTH/2
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset; one clock; reset is synchronous and active-low
- in_valid  input  1  operand pair A, B valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  WIDTH  multiplicand, two's complement
- B  input  WIDTH  multiplier, two's complement
- out_valid  output  1  product P valid
- out_ready  input  1  consumer accepts P
- P  output  2·WIDTH  signed product A·B
- busy  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch A into a_reg and B into b_reg, clear acc to 0, clear digit counter cnt to 0, go to RUN.
- RUN, one Booth digit per cycle, i = cnt:
  - Code = {b_reg[2i+1], b_reg[2i], b_reg[2i−1]}, with b_reg[−1] = 0.
  - Code → multiple: 000/111 → 0; 001/010 → +A; 011 → +2A; 100 → −2A; 101/110 → −A.
  - Form the partial product: sign-extend a_reg to WIDTH+1 bits, apply ×2 (shift left) and/or negate (two's complement), sign-extend to 2·WIDTH bits, shift left by 2i.
  - acc ← acc + pp, modulo 2^(2·WIDTH); discard the carry out.
  - cnt increments. When cnt = N−1, that digit is accumulated and the state goes to DONE.
- DONE:
  - out_valid = 1 and P = acc, both held stable until out_ready.
  - On out_ready: go to IDLE and deassert out_valid.
- P holds the last product after leaving DONE. It is not cleared until the next accept.
- Inputs A and B are ignored outside the accepting cycle. Changing them during RUN has no effect.
- Arithmetic is exact for all input pairs, including −2^(WIDTH−1) × −2^(WIDTH−1) = +2^(2·WIDTH−2), which fits in 2·WIDTH signed bits.

## Timing
- Reset (rst_n low at a rising edge):
  - State = IDLE, out_valid = 0, P = 0, acc = 0, cnt = 0, busy = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid is produced for the aborted operation.
- Latency: accept at edge 0; RUN occupies edges 1..N; out_valid is high from edge N+1 onward. For WIDTH = 8, out_valid rises 5 cycles after accept.
- Handshake rules:
  - in_ready and out_valid are never high in the same cycle.
  - in_valid while busy is not accepted, and the source must hold it.
- Back-to-back operation: out_ready high on the first DONE cycle gives IDLE on the next cycle. Minimum initiation interval is N+2 cycles.
- No early termination: all N digits are processed even when the remaining digits are zero.
- in_ready, out_valid and busy are decoded from registered state only. No combinational input-to-output paths exist.

## Test plan
- A=7, B=3, out_ready tied high → P=0x0015, out_valid high exactly at edge 5 after accept, for one cycle.
- Corner operands, one at a time:
  - −128 × −128 → P=0x4000.
  - −128 × 127 → P=0xC080.
  - −1 × −1 → P=0x0001.
  - 0 × −77 → P=0x0000.
- Backpressure: A=−5, B=9, out_ready low for 10 cycles → out_valid and P=0xFFD3 held stable throughout, in_ready low, new in_valid ignored. Raise out_ready → IDLE on the next cycle.
- Reset abort: assert rst_n low during the 2nd RUN cycle → next cycle out_valid=0, P=0, in_ready=1. Then 12 × −11 → P=0xFF7C.
- Back-to-back stream of 200 random pairs, in_valid always high, random out_ready → every P equals the reference signed product, with no drops or duplicates, and initiation interval ≥ 6.
